// File: rtl/mccpu_control.sv
`default_nettype none
// ============================================================================
// Module   : mccpu_control
// Purpose  : Multicycle control unit (IF/ID/EXE/MEM/WB) for the MIPS-subset
//            shared-ALU, single-memory datapath.
// Revision : 1.0 - initial release
// ============================================================================
module mccpu_control #(
    parameter logic [4:0] RA_IDX = 5'd31
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       sext,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic [3:0] aluc,
    output logic [2:0] dstate,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0100;
    localparam logic [3:0] c_ALU_AND = 4'b0001;
    localparam logic [3:0] c_ALU_OR  = 4'b0101;
    localparam logic [3:0] c_ALU_XOR = 4'b0010;
    localparam logic [3:0] c_ALU_LUI = 4'b0110;
    localparam logic [3:0] c_ALU_SLL = 4'b0011;
    localparam logic [3:0] c_ALU_SRL = 4'b0111;
    localparam logic [3:0] c_ALU_SRA = 4'b1111;

    // The datapath hardwires the link register; a zero index would drop every jal link.
    generate
        if (RA_IDX == 5'd0) begin : g_ra_idx_check
            $error("RA_IDX must select a writable register");
        end
    endgenerate

    state_t     r_state;
    state_t     w_state;
    state_t     w_next;
    logic       w_wpc, w_wir, w_wmem, w_wreg;
    logic       w_rtype, w_ralu, w_shift, w_jr;
    logic       w_ialu, w_addi, w_lw, w_sw, w_beq, w_bne, w_j, w_jal, w_legal;
    logic [3:0] w_raluc, w_ialuc;

    // Reset forces IF decode combinationally so outputs react before any edge.
    assign w_state = reset ? r_state : S_IF;
    assign w_rtype = (op == 6'b000000);

    always_comb begin
        w_ralu  = 1'b0;
        w_shift = 1'b0;
        w_jr    = 1'b0;
        w_raluc = c_ALU_ADD;
        unique case (func)
            6'b100000: begin w_ralu = 1'b1; w_raluc = c_ALU_ADD; end
            6'b100010: begin w_ralu = 1'b1; w_raluc = c_ALU_SUB; end
            6'b100100: begin w_ralu = 1'b1; w_raluc = c_ALU_AND; end
            6'b100101: begin w_ralu = 1'b1; w_raluc = c_ALU_OR;  end
            6'b100110: begin w_ralu = 1'b1; w_raluc = c_ALU_XOR; end
            6'b000000: begin w_ralu = 1'b1; w_shift = 1'b1; w_raluc = c_ALU_SLL; end
            6'b000010: begin w_ralu = 1'b1; w_shift = 1'b1; w_raluc = c_ALU_SRL; end
            6'b000011: begin w_ralu = 1'b1; w_shift = 1'b1; w_raluc = c_ALU_SRA; end
            6'b001000: w_jr = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        w_ialu  = 1'b0;
        w_addi  = 1'b0;
        w_lw    = 1'b0;
        w_sw    = 1'b0;
        w_beq   = 1'b0;
        w_bne   = 1'b0;
        w_j     = 1'b0;
        w_jal   = 1'b0;
        w_ialuc = c_ALU_ADD;
        unique case (op)
            6'b001000: begin w_ialu = 1'b1; w_addi = 1'b1; w_ialuc = c_ALU_ADD; end
            6'b001100: begin w_ialu = 1'b1; w_ialuc = c_ALU_AND; end
            6'b001101: begin w_ialu = 1'b1; w_ialuc = c_ALU_OR;  end
            6'b001110: begin w_ialu = 1'b1; w_ialuc = c_ALU_XOR; end
            6'b001111: begin w_ialu = 1'b1; w_ialuc = c_ALU_LUI; end
            6'b100011: w_lw  = 1'b1;
            6'b101011: w_sw  = 1'b1;
            6'b000100: w_beq = 1'b1;
            6'b000101: w_bne = 1'b1;
            6'b000010: w_j   = 1'b1;
            6'b000011: w_jal = 1'b1;
            default:   ;
        endcase
    end

    assign w_legal = w_rtype ? (w_ralu | w_jr)
                             : (w_ialu | w_lw | w_sw | w_beq | w_bne | w_j | w_jal);

    always_comb begin
        w_next   = S_IF;
        w_wpc    = 1'b0;
        w_wir    = 1'b0;
        w_wmem   = 1'b0;
        w_wreg   = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        sext     = 1'b0;
        alusrca  = 2'b00;
        alusrcb  = 2'b00;
        pcsource = 2'b00;
        aluc     = c_ALU_ADD;
        illegal  = 1'b0;
        case (w_state)
            S_IF: begin
                alusrcb = 2'b01;
                w_wpc   = mem_ready;
                w_wir   = mem_ready;
                w_next  = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                // PC already holds PC+4 here, so ALUOut latches the branch target.
                alusrcb = 2'b11;
                sext    = 1'b1;
                w_next  = S_EXE;
                if (!w_legal) begin
                    illegal = 1'b1;
                    w_next  = S_IF;
                end else if (!w_rtype && (w_j || w_jal)) begin
                    w_wpc    = 1'b1;
                    pcsource = 2'b11;
                    w_wreg   = w_jal;
                    jal      = w_jal;
                    w_next   = S_IF;
                end else if (w_rtype && w_jr) begin
                    w_wpc    = 1'b1;
                    pcsource = 2'b10;
                    w_next   = S_IF;
                end
            end
            S_EXE: begin
                if (w_rtype && w_ralu) begin
                    alusrca = w_shift ? 2'b10 : 2'b01;
                    aluc    = w_raluc;
                    w_next  = S_WB;
                end else if (!w_rtype && w_ialu) begin
                    alusrca = 2'b01;
                    alusrcb = 2'b10;
                    sext    = w_addi;
                    aluc    = w_ialuc;
                    w_next  = S_WB;
                end else if (w_lw || w_sw) begin
                    alusrca = 2'b01;
                    alusrcb = 2'b10;
                    sext    = 1'b1;
                    w_next  = S_MEM;
                end else if (w_beq || w_bne) begin
                    alusrca  = 2'b01;
                    aluc     = c_ALU_SUB;
                    pcsource = 2'b01;
                    w_wpc    = w_beq ? zero : ~zero;
                end
            end
            S_MEM: begin
                iord   = 1'b1;
                w_wmem = w_sw & mem_ready;
                w_next = !mem_ready ? S_MEM : (w_lw ? S_WB : S_IF);
            end
            S_WB: begin
                w_wreg = 1'b1;
                regrt  = ~w_rtype;
                m2reg  = w_lw;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    assign wpc    = w_wpc  & reset;
    assign wir    = w_wir  & reset;
    assign wmem   = w_wmem & reset;
    assign wreg   = w_wreg & reset;
    assign dstate = r_state;

endmodule
`default_nettype wire

// File: doc/mccpu_control.md
Name: mccpu_control

Overview:
- Multicycle control unit for the team's MIPS-subset CPU; replaces the single-cycle decoder of sccpu.
- Sequences a shared-ALU, single-memory datapath through the states IF, ID, EXE, MEM and WB.
- Generates the datapath enables, mux selects and ALU code from op/func/zero.
- Stalls in memory states until the memory handshake completes.

Parameters:
- RA_IDX, 5'd31, destination register index for jal.

Ports:
- clock in 1: system clock, rising edge.
- reset in 1: asynchronous, active-low (0 = reset asserted).
- op in 6: IR[31:26].
- func in 6: IR[5:0].
- zero in 1: ALU zero flag, combinational from the current ALU operation.
- mem_ready in 1: memory access completes this cycle.
- wpc out 1: PC write enable.
- wir out 1: IR write enable.
- wmem out 1: memory write enable.
- wreg out 1: register file write enable.
- iord out 1: memory address select; 0 = PC, 1 = ALUOut.
- regrt out 1: destination register select; 1 = rt, 0 = rd.
- m2reg out 1: writeback data select; 1 = MDR, 0 = ALUOut.
- jal out 1: forces destination RA_IDX and writeback data PC.
- sext out 1: 1 = sign-extend imm16, 0 = zero-extend.
- alusrca out 2: ALU A source; 00 PC, 01 qa, 10 sa.
- alusrcb out 2: ALU B source; 00 qb, 01 const 4, 10 ext imm, 11 sext(imm)<<2.
- pcsource out 2: next-PC source; 00 ALU result, 01 ALUOut, 10 qa, 11 {PC[31:28],addr26,2'b00}.
- aluc out 4: ALU operation code.
- dstate out 3: current state, for debug.
- illegal out 1: unsupported instruction decoded.

Behaviour:
- State encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4. The state register is the only storage.
- Outputs are combinational from state, op, func, zero and mem_ready.
- Reset low: state=IF immediately. wpc, wir, wmem and wreg are forced to 0 while reset is low; every other output takes its IF value.
- Any output not listed for a state is 0, except aluc, which is add (0000).
- ALU codes: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
- Supported R-type (op=000000), by func: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
- Supported I/J-type, by op: addi 001000, andi 001100, ori 001101, xori 001110, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
- IF:
  - Outputs: iord=0, alusrca=00, alusrcb=01, pcsource=00.
  - wir=wpc=mem_ready.
  - mem_ready=0: hold in IF, no PC or IR update. mem_ready=1: go to ID.
- ID:
  - Outputs: alusrca=00, alusrcb=11, sext=1 (ALUOut captures the branch target).
  - j: wpc=1, pcsource=11, go to IF.
  - jal: as j, plus wreg=1 and jal=1; this writes the current PC (already PC+4). Go to IF.
  - jr: wpc=1, pcsource=10, go to IF.
  - Illegal op/func: illegal=1 for this cycle, no writes, go to IF (executes as a nop).
  - All others: go to EXE.
- EXE:
  - R-type ALU ops: alusrca=01 (10 for sll/srl/sra), alusrcb=00, aluc per func. Go to WB.
  - addi/andi/ori/xori/lui: alusrca=01, alusrcb=10, aluc per op; sext=1 only for addi. Go to WB.
  - lw/sw: alusrca=01, alusrcb=10, sext=1, aluc=add. Go to MEM.
  - beq/bne: alusrca=01, alusrcb=00, aluc=sub, pcsource=01.
    - wpc = zero for beq, ~zero for bne.
    - Go to IF.
- MEM:
  - Outputs: iord=1. For sw, wmem=mem_ready.
  - mem_ready=0: hold in MEM.
  - mem_ready=1: lw goes to WB; sw goes to IF.
- WB:
  - Outputs: wreg=1.
  - regrt=1 for I-type; m2reg=1 for lw.
  - Go to IF.
- Cycle counts with mem_ready tied to 1:
  - j, jal, jr, illegal: 2.
  - beq, bne: 3.
  - sw: 4.
  - ALU ops: 4.
  - lw: 5.
  - Each mem_ready=0 cycle in IF or MEM adds one cycle.
- Reset asserted in any state, including a stalled MEM of sw: wmem drops to 0 in the same cycle and the state returns to IF.
- Unreachable state encodings 5 to 7 go to IF on the next clock with all writes 0.

Test Plan:
- add (op 000000, func 100000), mem_ready=1: dstate sequence 0,1,2,4,0. wreg=1, regrt=0, aluc=0000 in WB; wir=wpc=1 only in IF.
- lw with mem_ready low for 2 cycles in MEM: dstate 0,1,2,3,3,3,4,0. iord=1 throughout MEM; m2reg=1, regrt=1, wreg=1 in WB.
- beq with zero=1, then with zero=0: in EXE, wpc=1 / wpc=0 respectively, pcsource=01, aluc=0100; both return to IF.
- jal: in ID, wpc=1, wreg=1, jal=1, pcsource=11; next dstate=0; total 2 cycles.
- sw stalled in MEM, reset pulled low mid-stall: wmem=0 in the same cycle; after reset is released, dstate=0 and wpc=wir=1 once mem_ready=1.
- op=111111: illegal=1 in ID only, no write enables asserted, dstate 0,1,0.
